// File: rtl/supervision_video_pkg.sv
// supervision_video_pkg: shared video types, default geometry and LCD palettes
package supervision_video_pkg;
  typedef enum logic [1:0] {CLEAR, WAIT_VB, RUN} state_t;
  localparam int H_ACTIVE_DEF = 160;
  localparam int V_ACTIVE_DEF = 160;
  // Entry 0 is the lightest shade and entry 15 the darkest.
  localparam logic [23:0] PAL_GREEN [16] = '{
    24'hC0E080, 24'hB4D378, 24'hA8C670, 24'h9CB968,
    24'h90AC60, 24'h849F58, 24'h789250, 24'h6C8548,
    24'h607840, 24'h546B38, 24'h485E30, 24'h3C5128,
    24'h304420, 24'h243718, 24'h182A10, 24'h0C1D08
  };
  localparam logic [23:0] PAL_GREY [16] = '{
    24'hFFFFFF, 24'hEEEEEE, 24'hDDDDDD, 24'hCCCCCC,
    24'hBBBBBB, 24'hAAAAAA, 24'h999999, 24'h888888,
    24'h777777, 24'h666666, 24'h555555, 24'h444444,
    24'h333333, 24'h222222, 24'h111111, 24'h000000
  };
endpackage

// File: rtl/dpram.sv
// dpram: simple dual-port RAM, write on port A, registered read on port B
module dpram #(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clock,
  input  logic [addr_width-1:0] address_a,
  input  logic [data_width-1:0] data_a,
  input  logic                  wren_a,
  input  logic [addr_width-1:0] address_b,
  output logic [data_width-1:0] q_b
);
  logic [data_width-1:0] mem [2**addr_width];
  always_ff @(posedge clock) begin
    if (wren_a) mem[address_a] <= data_a;
    q_b <= mem[address_b];
  end
endmodule

// File: rtl/lcd_ghost.sv
// lcd_ghost: STN-panel ghosting emulation with per-pixel frame history and palette lookup
module lcd_ghost
  import supervision_video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic [1:0] pixel,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       hblank,
  input  logic       vblank,
  input  logic       ghost_en,
  input  logic       palette,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hs_out,
  output logic       vs_out,
  output logic       hb_out,
  output logic       vb_out,
  output logic       ce_out
);
  localparam logic [14:0] HV = 15'(H_ACTIVE * V_ACTIVE);
  state_t state, state_nx;
  logic [14:0] addr, clr_addr, addr_a;
  logic [7:0] x, q, data_a;
  logic [3:0] t, n, lvl;
  logic [4:0] sum;
  logic active, wr, clearing, unused_q;
  assign unused_q = ^q[7:4];
  assign clearing = state == CLEAR;
  assign active = ~hblank & ~vblank;
  assign t = 4'(pixel) * 4'd5;
  assign sum = 5'(q[3:0]) + 5'(t) + 5'd1;
  assign n = (ghost_en && state == RUN) ? sum[4:1] : t;
  assign lvl = active ? n : 4'd0;
  assign wr = state == RUN && pix_ce && active && x < 8'(H_ACTIVE) && addr < HV;
  assign addr_a = clearing ? clr_addr : addr;
  assign data_a = clearing ? 8'd0 : {4'd0, n};
  always_comb begin
    state_nx = state;
    state_nx = (clearing && clr_addr == HV - 15'd1) ? WAIT_VB
             : (state == WAIT_VB && pix_ce && vblank) ? RUN : state;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= CLEAR;
      clr_addr <= '0;
      addr <= '0;
      x <= '0;
      {red, green, blue} <= '0;
      {hs_out, vs_out, hb_out, vb_out, ce_out} <= '0;
    end else begin
      state <= state_nx;
      ce_out <= pix_ce;
      if (clearing) clr_addr <= clr_addr + 15'd1;
      if (pix_ce && !clearing) begin
        x <= hblank ? 8'd0 : wr ? x + 8'd1 : x;
        addr <= vblank ? 15'd0 : wr ? addr + 15'd1 : addr;
      end
      if (pix_ce) begin
        {red, green, blue} <= palette ? PAL_GREY[lvl] : PAL_GREEN[lvl];
        {hs_out, vs_out, hb_out, vb_out} <= {hsync, vsync, hblank, vblank};
      end
    end
  end
  // History read always tracks addr, so H is ready by the next strobe.
  dpram #(.addr_width(15), .data_width(8)) u_ram (
    .clock(clk_sys),
    .address_a(addr_a),
    .data_a(data_a),
    .wren_a(clearing | wr),
    .address_b(addr),
    .q_b(q)
  );
endmodule

// File: tb/tb_lcd_ghost.sv
// tb_lcd_ghost: directed-vector bench for lcd_ghost on a reduced 8x4 frame
module tb_lcd_ghost;
  import supervision_video_pkg::*;
  localparam int H = 8;
  localparam int V = 4;
  localparam int HV = H * V;
  logic clk_sys = 0, reset = 1, pix_ce = 0, hsync = 0, vsync = 0, hblank = 0, vblank = 0;
  logic ghost_en = 0, palette = 1;
  logic [1:0] pixel = 0;
  logic [7:0] red, green, blue;
  logic hs_out, vs_out, hb_out, vb_out, ce_out;
  logic [23:0] got;
  int n_vec = 0, n_bad = 0;

  lcd_ghost #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk_sys(clk_sys), .reset(reset), .pix_ce(pix_ce), .pixel(pixel),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .ghost_en(ghost_en), .palette(palette),
    .red(red), .green(green), .blue(blue),
    .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out), .ce_out(ce_out)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] grey(input int l);
    logic [7:0] v;
    v = 8'(255 - 17 * l);
    return {v, v, v};
  endfunction

  task automatic strobe(input logic [1:0] p, input logic hb, input logic vb);
    pixel = p; hblank = hb; vblank = vb; hsync = hb; vsync = vb; pix_ce = 1;
    @(posedge clk_sys); #1;
    pix_ce = 0;
    got = {red, green, blue};
    chk("ce_hi", 32'(ce_out), 1);
    chk("hb_out", 32'(hb_out), 32'(hb));
    chk("vs_out", 32'(vs_out), 32'(vb));
    @(posedge clk_sys); #1;
    chk("ce_lo", 32'(ce_out), 0);
    chk("rgb_hold", 32'({red, green, blue}), 32'(got));
  endtask

  task automatic frame(input logic [1:0] p, input logic [23:0] exp, input int lines = V);
    strobe(2'd0, 1'b1, 1'b1);
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < H; c++) begin
        strobe(p, 1'b0, 1'b0);
        chk("pix_rgb", 32'(got), 32'(exp));
      end
      strobe(2'd0, 1'b1, 1'b0);
      chk("hblank_rgb", 32'(got), 32'(exp_blank()));
    end
  endtask

  function automatic logic [23:0] exp_blank();
    return palette ? 24'hFFFFFF : 24'hC0E080;
  endfunction

  initial begin
    int nz;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_rgb", 32'({red, green, blue}), 0);
    chk("rst_ce", 32'(ce_out), 0);
    chk("rst_sync", 32'({hs_out, vs_out, hb_out, vb_out}), 0);
    chk("rst_state", 32'(dut.state), 32'(CLEAR));
    chk("rst_addr", 32'(dut.addr), 0);
    reset = 0;
    strobe(2'd3, 1'b0, 1'b0);
    chk("clear_rgb", 32'(got), 32'(grey(15)));
    chk("clear_state", 32'(dut.state), 32'(CLEAR));
    repeat (40) @(posedge clk_sys);
    #1;
    chk("wait_state", 32'(dut.state), 32'(WAIT_VB));
    strobe(2'd0, 1'b1, 1'b1);
    chk("run_state", 32'(dut.state), 32'(RUN));
    chk("vb_rgb", 32'(got), 32'h00FFFFFF);
    // ghost off
    frame(2'd3, grey(15));
    frame(2'd0, grey(0));
    // green palette spot checks
    palette = 0;
    frame(2'd3, 24'h0C1D08, 1);
    palette = 1;
    frame(2'd0, grey(0));
    // step response from zero history
    ghost_en = 1;
    frame(2'd3, grey(8));
    frame(2'd3, grey(12));
    frame(2'd3, grey(14));
    frame(2'd3, grey(15));
    frame(2'd3, grey(15));
    // decay
    frame(2'd0, grey(8));
    frame(2'd0, grey(4));
    // overlong line then overlong frame
    ghost_en = 0;
    strobe(2'd0, 1'b1, 1'b1);
    for (int c = 0; c < H + 2; c++) begin
      strobe(2'd3, 1'b0, 1'b0);
      chk("long_rgb", 32'(got), 32'(grey(15)));
    end
    chk("long_x", 32'(dut.x), H);
    chk("long_addr", 32'(dut.addr), H);
    chk("mem_last", 32'(dut.u_ram.mem[H-1][3:0]), 15);
    chk("mem_nowr", 32'(dut.u_ram.mem[H][3:0]), 4);
    strobe(2'd0, 1'b1, 1'b0);
    chk("next_x", 32'(dut.x), 0);
    chk("next_addr", 32'(dut.addr), H);
    for (int l = 1; l <= V; l++) begin
      for (int c = 0; c < H; c++) begin
        strobe(2'd3, 1'b0, 1'b0);
        chk("sat_rgb", 32'(got), 32'(grey(15)));
      end
      strobe(2'd0, 1'b1, 1'b0);
    end
    chk("sat_addr", 32'(dut.addr), HV);
    chk("mem_end", 32'(dut.u_ram.mem[HV-1][3:0]), 15);
    chk("mem_nowrap", 32'(dut.u_ram.mem[0][3:0]), 15);
    // reset mid-frame
    frame(2'd3, grey(15), 2);
    reset = 1;
    @(posedge clk_sys); #1;
    chk("mid_rgb", 32'({red, green, blue}), 0);
    chk("mid_hb", 32'(hb_out), 0);
    chk("mid_state", 32'(dut.state), 32'(CLEAR));
    chk("mid_clr", 32'(dut.clr_addr), 0);
    reset = 0;
    strobe(2'd0, 1'b1, 1'b1);
    chk("mid_ignore", 32'(dut.state), 32'(CLEAR));
    repeat (40) @(posedge clk_sys);
    #1;
    chk("mid_wait", 32'(dut.state), 32'(WAIT_VB));
    nz = 0;
    for (int i = 0; i < HV; i++) if (dut.u_ram.mem[i] != 8'd0) nz++;
    chk("ram_zero", 32'(nz), 0);
    strobe(2'd3, 1'b0, 1'b0);
    chk("wait_rgb", 32'(got), 32'(grey(15)));
    chk("wait_nowr", 32'(dut.u_ram.mem[0]), 0);
    ghost_en = 1;
    frame(2'd3, grey(8));
    chk("final_state", 32'(dut.state), 32'(RUN));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
